// File: rtl/rv16_pkg.sv
// -----------------------------------------------------------------------------
// rv16_pkg
// Shared constants and types for the rv16 add sequencer.
//   XLEN   : operand/result width
//   DATA   : width of one slice handed to the slice adder
//   NSLICE : number of slices per operation (XLEN/DATA)
//   KW     : width of the slice index counter
//   addseq_state_t : sequencer FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package rv16_pkg;

    localparam int XLEN   = 16;
    localparam int DATA   = 4;
    localparam int NSLICE = XLEN / DATA;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addseq_state_t;

endpackage

// File: rtl/rv16_slice_mux.sv
// -----------------------------------------------------------------------------
// rv16_slice_mux
// Combinational selector returning DATA-wide slice number idx of an XLEN word.
// Ports:
//   word  (in)  XLEN-bit source word
//   idx   (in)  slice index, 0 = least-significant slice
//   slice (out) word[idx*DATA +: DATA]
// -----------------------------------------------------------------------------
module rv16_slice_mux #(
    parameter int XLEN = 16,
    parameter int DATA = 4,
    parameter int KW   = 2
) (
    input  logic [XLEN-1:0] word,
    input  logic [KW-1:0]   idx,
    output logic [DATA-1:0] slice
);

    assign slice = word[idx*DATA +: DATA];

endmodule

// File: rtl/rv16_add_sequencer.sv
// -----------------------------------------------------------------------------
// rv16_add_sequencer
// Feeds a 16-bit add/subtract to the external combinational 4-bit slice adder
// one slice per cycle (LSB slice first), chaining the carry through a register,
// and presents the assembled result plus cout/ovf/zero on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE and the result/flags hold until the next request is accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   op_a, op_b, op_cin, op_sub request operands
//   slice_a, slice_b, slice_cin  drive to the slice adder (0 outside RUN)
//   slice_sum, slice_cout        response from the slice adder
//   out_valid/out_ready        result handshake
//   result, cout, ovf, zero    result and flags
//
// Build option: RV16_ADDSEQ_SUB_EN -- when defined op_sub selects A - B
// (B inverted, initial carry 1); when undefined op_sub is ignored.
// -----------------------------------------------------------------------------
module rv16_add_sequencer #(
    parameter int XLEN = rv16_pkg::XLEN,
    parameter int DATA = rv16_pkg::DATA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            op_cin,
    input  logic            op_sub,
    output logic [DATA-1:0] slice_a,
    output logic [DATA-1:0] slice_b,
    output logic            slice_cin,
    input  logic [DATA-1:0] slice_sum,
    input  logic            slice_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cout,
    output logic            ovf,
    output logic            zero
);
    import rv16_pkg::*;

    localparam int NSL = XLEN / DATA;
    localparam int KWL = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KWL-1:0] K_LAST = KWL'(NSL - 1);

    addseq_state_t   state_q, state_d;
    logic [KWL-1:0]  k_q, k_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic [XLEN-1:0] b_eff;
    logic            cin_init;
    logic [DATA-1:0] a_slice, b_slice;
    logic [XLEN-1:0] sum_full;

`ifdef RV16_ADDSEQ_SUB_EN
    assign b_eff    = op_sub ? ~op_b : op_b;
    assign cin_init = op_sub ? 1'b1 : op_cin;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_eff         = op_b;
    assign cin_init      = op_cin;
`endif

    rv16_slice_mux #(.XLEN(XLEN), .DATA(DATA), .KW(KWL)) u_mux_a (
        .word  (a_q),
        .idx   (k_q),
        .slice (a_slice)
    );

    rv16_slice_mux #(.XLEN(XLEN), .DATA(DATA), .KW(KWL)) u_mux_b (
        .word  (b_q),
        .idx   (k_q),
        .slice (b_slice)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        // Result as it will look once the current slice is written; on the
        // last slice this is the complete sum used for the flags.
        sum_full  = result_q;
        sum_full[k_q*DATA +: DATA] = slice_sum;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = b_eff;
                    carry_d = cin_init;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                slice_a   = a_slice;
                slice_b   = b_slice;
                slice_cin = carry_q;
                result_d  = sum_full;
                carry_d   = slice_cout;
                k_d       = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[XLEN-1] == b_q[XLEN-1]) &&
                              (sum_full[XLEN-1] != a_q[XLEN-1]);
                    zero_d  = (sum_full == '0);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_rv16_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rv16_add_sequencer
// Bench for rv16_add_sequencer with a behavioural slice adder attached.
// Expected results come from whole-word arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_rv16_add_sequencer;

    localparam int XLEN   = 16;
    localparam int DATA   = 4;
    localparam int NSLICE = XLEN / DATA;

    // clock / reset ----------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT ----------------------------------------------------------------------
    logic            in_valid, in_ready;
    logic [XLEN-1:0] op_a, op_b;
    logic            op_cin, op_sub;
    logic [DATA-1:0] slice_a, slice_b, slice_sum;
    logic            slice_cin, slice_cout;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] result;
    logic            cout, ovf, zero;

    rv16_add_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .op_sub     (op_sub),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .cout       (cout),
        .ovf        (ovf),
        .zero       (zero)
    );

    // behavioural 4-bit slice adder
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

    // scoreboard -------------------------------------------------------------
    // entry = {accept_cycle[15:0], zero, ovf, cout, result[15:0]}
    logic [34:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    bit rnd_ready = 1'b0;
    bit seen = 1'b0;
    int hs_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on whole words.
    function automatic logic [18:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] be;
        logic        c;
        logic [16:0] u;
        int          sa;
        be = b;
        c  = cin;
`ifdef RV16_ADDSEQ_SUB_EN
        if (sub) begin
            be = ~b;
            c  = 1'b1;
        end
`else
        if (sub) c = cin;
`endif
        u  = {1'b0, a} + {1'b0, be} + {16'b0, c};
        sa = int'($signed(a)) + int'($signed(be)) + int'(c);
        return {(u[15:0] == 16'h0), (sa > 32767 || sa < -32768), u[16], u[15:0]};
    endfunction

    // driver -----------------------------------------------------------------
    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, output int acc);
        int n = 0;
        in_valid = 1'b1;
        op_a = a; op_b = b; op_cin = cin; op_sub = sub;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!in_ready) begin
            chk("accept_timeout", 32'(n), 32'(0));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        exp_q.push_back({acc[15:0], ref_add(a, b, cin, sub)});
        // scramble inputs to show they are not used after acceptance
        in_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        op_cin = 1'($urandom); op_sub = 1'($urandom);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_result"},    32'(result),    32'(0));
        chk({tag, "_flags"},     32'({cout, ovf, zero}), 32'(0));
        chk({tag, "_slices"},    32'({slice_a, slice_b, slice_cin}), 32'(0));
    endtask

    // monitor ----------------------------------------------------------------
    always @(negedge clk) begin
        logic [34:0] e;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(1), 32'(0));
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    chk("latency", 32'(cyc - int'(e[34:19])), 32'(NSLICE));
                    seen = 1'b1;
                end
                chk("result", 32'(result), 32'(e[15:0]));
                chk("cout",   32'(cout),   32'(e[16]));
                chk("ovf",    32'(ovf),    32'(e[17]));
                chk("zero",   32'(zero),   32'(e[18]));
                chk("in_ready_in_done", 32'(in_ready), 32'(0));
                chk("slices_idle", 32'({slice_a, slice_b, slice_cin}), 32'(0));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen   = 1'b0;
                    hs_cyc = cyc;
                end
            end
        end
    end

    // test sequence ----------------------------------------------------------
    int acc1, acc2;
    logic [15:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed corner cases
        send(16'h1234, 16'h4321, 1'b0, 1'b0, acc1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc1);
        drain();
        send(16'h0005, 16'h0007, 1'b0, 1'b1, acc1);
        drain();
        send(16'h8000, 16'h8000, 1'b1, 1'b0, acc1);
        drain();

        // result held in DONE while a new request waits
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, acc1);
        fork
            send(16'hABCD, 16'h1357, 1'b1, 1'b0, acc2);
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        chk("accept_after_handshake", 32'(acc2 - hs_cyc), 32'(2));
        drain();

        // reset during RUN after slice 2 captured
        send(16'h4444, 16'h3333, 1'b0, 1'b0, acc1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset("abort");
        void'(exp_q.pop_back());
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NSLICE + 3) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'(0));
        end
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, acc1);
        drain();

        // randomized traffic with random output back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
            send(a, b, 1'($urandom), 1'($urandom), acc1);
        end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv16_add_sequencer.md
# rv16_add_sequencer

Multi-cycle operand sequencer that sits directly upstream of the rv16 4-bit slice adder. It accepts a 16-bit add/subtract request and feeds the slice adder one DATA-wide nibble per cycle, least-significant first, chaining the carry through a register. It collects the sum slices and presents the 16-bit result with carry, overflow and zero flags on a valid/ready output. Throughout, "slice adder" means the combinational rv16 4-bit slice adder this block drives.

## Interface
Parameters:
- XLEN, 16, operand/result width; must be an integer multiple of DATA.
- DATA, 4, slice width; must match the slice adder's DATA.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B.
- op_cin  input  1  carry-in for an add.
- op_sub  input  1  1 = A − B (see Configuration).
- slice_a  output  DATA  A slice to the slice adder.
- slice_b  output  DATA  effective B slice to the slice adder.
- slice_cin  output  1  carry into the current slice.
- slice_sum  input  DATA  sum from the slice adder (combinational).
- slice_cout  input  1  carry-out from the slice adder.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  sum.
- cout  output  1  final carry-out.
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- NSLICE = XLEN/DATA (4 by default). Slice index k is 0..NSLICE−1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op_a, the effective B and the initial carry, clear k, and go to RUN.
  - RUN: drive slice k. At each edge, write slice_sum into result[k*DATA +: DATA], load slice_cout into the carry register, and increment k. Leave for DONE at the edge where k=NSLICE−1.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Effective B = op_sub ? ~op_b : op_b. Initial carry = op_sub ? 1 : op_cin.
- slice_a, slice_b and slice_cin are 0 outside RUN.
- Flags are captured at the last RUN edge:
  - cout = slice_cout.
  - ovf = (A[XLEN−1] == Beff[XLEN−1]) && (sum[XLEN−1] != A[XLEN−1]).
  - zero = (full result == 0).
- For a subtract, cout=1 means no borrow.
- in_ready is high only in IDLE. Requests in RUN/DONE are not accepted; the source holds them.
- result, cout, ovf and zero stay stable from DONE entry until the next acceptance.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, slice outputs 0, state IDLE, k=0.
- Acceptance at edge E0. Slice k is captured at edge E(k+1). out_valid rises after edge E(NSLICE), i.e. NSLICE cycles after acceptance.
- Output handshake at edge Ed returns to IDLE. The earliest next acceptance is at edge Ed+1. Peak throughput is one op per NSLICE+2 cycles.
- out_ready held low: DONE persists indefinitely, outputs frozen.
- rst_n asserted mid-RUN or in DONE: the operation is abandoned immediately and no out_valid is produced.
- Input changes after acceptance have no effect; operands are latched.

## Configuration
- RV16_ADDSEQ_SUB_EN defined: op_sub is honoured as specified above.
- RV16_ADDSEQ_SUB_EN undefined:
  - op_sub is ignored; B is never inverted and the initial carry = op_cin.
  - Port list is unchanged.
  - ovf is computed against the uninverted B.

## Structure
- Shared package rv16_pkg holds:
  - XLEN and DATA constants.
  - NSLICE derived constant.
  - the addseq_state_t enum (IDLE, RUN, DONE).
- One sub-module is natural: rv16_slice_mux, a combinational selector returning the DATA-wide slice k of an XLEN word. It is instantiated for A and for effective B.
- The slice adder is instantiated beside this block at the next level up, not inside it.

## Test plan
- 0x1234 + 0x4321, cin=0: result=0x5555, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after acceptance.
- 0xFFFF + 0x0001: result=0x0000, cout=1, zero=1, ovf=0; carry chains through all 4 slices.
- 0x7FFF + 0x0001: result=0x8000, ovf=1, cout=0.
- SUB enabled, 0x0005 − 0x0007: result=0xFFFE, cout=0, ovf=0. With the macro off, the same stimulus gives 0x000C.
- out_ready low for 3 cycles in DONE with in_valid=1 and new operands: result and flags stable, in_ready=0, new request accepted only in the cycle after the output handshake.
- rst_n pulsed low after slice 2 capture: all outputs return to reset values, out_valid never asserts; the next request 0x00FF + 0x0001 yields 0x0100.
